// File: rtl/slave_worker_fsm_pkg.sv
// Shared definitions for the slave worker: state encoding seen by the master sequencer.
package slave_worker_fsm_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StDrain = 2'b10,
        StFault = 2'b11
    } state_e;

    localparam int unsigned DRAIN_CNT_W = 8;

endpackage

// File: rtl/slave_worker_fsm_cycle_counter.sv
// Up-counter that clears on load, advances when enabled and saturates at its terminal value.
module slave_worker_fsm_cycle_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] count_q;

    assign tc    = (count_q == last);
    assign count = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= '0;
        end else if (en && !tc) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/slave_worker_fsm.sv
// Responder side of the start/busy/done handshake: runs a len_in-cycle job plus a fixed drain.
module slave_worker_fsm
    import slave_worker_fsm_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned DRAIN_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len_in,
    input  logic             abort,
    output logic [1:0]       state,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] count
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_CYC - 1);

    state_e                 state_q, state_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [CNT_W-1:0]       len_q;
    logic                   accept;
    logic                   run_tc;
    logic                   drain_tc;
    logic [DRAIN_CNT_W-1:0] drain_count;

    assign accept = (state_q == StIdle) && start;

    slave_worker_fsm_cycle_counter #(
        .W(CNT_W)
    ) u_run_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .en    ((state_q == StRun) && !abort),
        .last  (len_q - 1'b1),
        .count (count),
        .tc    (run_tc)
    );

    // Held cleared outside DRAIN so every drain phase starts from zero.
    slave_worker_fsm_cycle_counter #(
        .W(DRAIN_CNT_W)
    ) u_drain_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state_q != StDrain),
        .en    (state_q == StDrain),
        .last  (DRAIN_LAST),
        .count (drain_count),
        .tc    (drain_tc)
    );

    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = (len_in != '0) ? StRun : StFault;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StFault;
                end else if (run_tc) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (abort) begin
                    state_d = StFault;
                end else if (drain_tc) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            StFault: begin
                state_d = StIdle;
                done_d  = 1'b1;
                err_d   = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (accept && (len_in != '0)) begin
                len_q <= len_in;
            end
        end
    end

    assign state = state_q;
    assign busy  = (state_q != StIdle);
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_slave_worker_fsm.sv
// Directed bench for slave_worker_fsm with hand-computed expectations (CNT_W=16, DRAIN_CYC=2).
module tb_slave_worker_fsm;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_DRAIN = 2'b10;
    localparam logic [1:0] S_FAULT = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] len_in;
    logic        abort;
    logic [1:0]  state;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] count;

    int unsigned n_checks;
    int unsigned n_pass;

    slave_worker_fsm #(
        .CNT_W     (16),
        .DRAIN_CYC (2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .len_in (len_in),
        .abort  (abort),
        .state  (state),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [1:0] st, input logic bsy,
                             input logic dn, input logic er, input logic [15:0] cnt);
        check({tag, "_state"}, 32'(state), 32'(st));
        check({tag, "_busy"},  32'(busy),  32'(bsy));
        check({tag, "_done"},  32'(done),  32'(dn));
        check({tag, "_err"},   32'(err),   32'(er));
        check({tag, "_count"}, 32'(count), 32'(cnt));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        len_in   = '0;
        abort    = 1'b0;
        tick(2);
        check_out("reset", S_IDLE, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick(1);

        // Normal job, len 3: 3 RUN cycles, 2 DRAIN cycles.
        start = 1'b1; len_in = 16'd3;
        tick(1);
        start = 1'b0;
        check_out("t1_start", S_RUN, 1, 0, 0, 0);
        tick(1); check_out("t1_run1", S_RUN, 1, 0, 0, 1);
        tick(1); check_out("t1_run2", S_RUN, 1, 0, 0, 2);
        tick(1); check_out("t1_drain0", S_DRAIN, 1, 0, 0, 2);
        tick(1); check_out("t1_drain1", S_DRAIN, 1, 0, 0, 2);
        tick(1); check_out("t1_done", S_IDLE, 0, 1, 0, 2);

        // Zero-length request: one FAULT cycle, then done+err.
        start = 1'b1; len_in = 16'd0;
        tick(1);
        start = 1'b0;
        check_out("t2_fault", S_FAULT, 1, 0, 0, 0);
        tick(1); check_out("t2_done", S_IDLE, 0, 1, 1, 0);

        // Abort during the 4th RUN cycle of a len 10 job.
        start = 1'b1; len_in = 16'd10;
        tick(1);
        start = 1'b0;
        check_out("t3_start", S_RUN, 1, 0, 0, 0);
        tick(3);
        check_out("t3_run4", S_RUN, 1, 0, 0, 3);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check_out("t3_fault", S_FAULT, 1, 0, 0, 3);
        tick(1); check_out("t3_done", S_IDLE, 0, 1, 1, 3);

        // Second start while running is ignored.
        start = 1'b1; len_in = 16'd4;
        tick(2);
        len_in = 16'd100;
        tick(1);
        start = 1'b0;
        check_out("t4_ignored", S_RUN, 1, 0, 0, 2);
        tick(1); check_out("t4_run3", S_RUN, 1, 0, 0, 3);
        tick(1); check_out("t4_drain", S_DRAIN, 1, 0, 0, 3);
        tick(2); check_out("t4_done", S_IDLE, 0, 1, 0, 3);

        // Asynchronous reset in the middle of DRAIN.
        start = 1'b1; len_in = 16'd2;
        tick(1);
        start = 1'b0;
        tick(2);
        check_out("t5_drain", S_DRAIN, 1, 0, 0, 1);
        #2 rst_n = 1'b0;
        #1 check_out("t5_async", S_IDLE, 0, 0, 0, 0);
        #1 rst_n = 1'b1;
        tick(1);
        start = 1'b1; len_in = 16'd1;
        tick(1);
        start = 1'b0;
        check_out("t5_rerun", S_RUN, 1, 0, 0, 0);
        tick(1); check_out("t5_drain2", S_DRAIN, 1, 0, 0, 0);
        tick(2); check_out("t5_done", S_IDLE, 0, 1, 0, 0);

        // Back-to-back: done from the previous job clears on the next start.
        start = 1'b1; len_in = 16'd5;
        tick(1);
        start = 1'b0;
        check_out("t6_start", S_RUN, 1, 0, 0, 0);
        tick(6); check_out("t6_drain", S_DRAIN, 1, 0, 0, 4);
        tick(1); check_out("t6_done", S_IDLE, 0, 1, 0, 4);

        // Abort on the terminal RUN cycle wins over the move to DRAIN; start beats abort in IDLE.
        start = 1'b1; abort = 1'b1; len_in = 16'd1;
        tick(1);
        start = 1'b0;
        check_out("t7_start_wins", S_RUN, 1, 0, 0, 0);
        tick(1);
        abort = 1'b0;
        check_out("t7_abort_tc", S_FAULT, 1, 0, 0, 0);
        tick(1); check_out("t7_done", S_IDLE, 0, 1, 1, 0);

        // Abort in IDLE is ignored.
        abort = 1'b1;
        tick(2);
        abort = 1'b0;
        check_out("t8_idle_abort", S_IDLE, 0, 1, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
